// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter for the valid/ready memory bus (CPU = master 0, DMA = master 1).
// A per-transaction watchdog aborts hung slave accesses with an error word and a sticky flag.
`timescale 1ns/1ps

module soc_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        sel_valid;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        in_busy;
    logic        in_abort;
    logic        xfer_done;
    logic        resp_ready;
    logic [31:0] resp_rdata;

    // Slave-side response is forwarded only to the current owner and only while it is owned.
    always_comb begin
        sel_valid  = grant_q ? m1_valid : m0_valid;
        sel_addr   = grant_q ? m1_addr  : m0_addr;
        sel_wdata  = grant_q ? m1_wdata : m0_wdata;
        sel_wstrb  = grant_q ? m1_wstrb : m0_wstrb;
        in_busy    = (state_q == ST_BUSY);
        in_abort   = (state_q == ST_ABORT);
        xfer_done  = in_busy && sel_valid && s_ready;
        resp_ready = xfer_done || in_abort;
        resp_rdata = '0;
        if (in_abort) begin
            resp_rdata = ERR_RDATA;
        end else if (xfer_done) begin
            resp_rdata = s_rdata;
        end

        s_valid  = in_busy && sel_valid;
        s_addr   = in_busy ? sel_addr  : '0;
        s_wdata  = in_busy ? sel_wdata : '0;
        s_wstrb  = in_busy ? sel_wstrb : '0;
        m0_ready = resp_ready && !grant_q;
        m0_rdata = grant_q ? '0 : resp_rdata;
        m1_ready = resp_ready && grant_q;
        m1_rdata = grant_q ? resp_rdata : '0;
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        count_d       = count_q;
        timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    state_d = ST_BUSY;
                    count_d = '0;
                end
            end
            ST_BUSY: begin
                if (xfer_done || !sel_valid) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else begin
                    if (WDOG_EN && (count_q == CNT_LAST)) begin
                        state_d = ST_ABORT;
                    end
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                // Setting the error flag here takes priority over a simultaneous err_clr.
                timeout_err_d = 1'b1;
                last_d        = grant_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter: a scoreboard of expected master responses is
// filled as requests are issued and drained by a monitor whenever a master sees ready.
`timescale 1ns/1ps

module tb_soc_bus_arbiter;

    typedef struct packed {
        logic        master;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        err_clr;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        s_ready_man;
    logic [31:0] s_rdata_man;
    logic        slave_auto;
    logic        mon_sel;

    logic        a_m0_ready, a_m1_ready, a_s_valid, a_grant, a_busy, a_timeout_err;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic [3:0]  a_s_wstrb;
    logic        b_m0_ready, b_m1_ready, b_s_valid, b_grant, b_busy, b_timeout_err;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
    logic [3:0]  b_s_wstrb;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Zero-wait slave answers in the same cycle as the short-timeout instance requests.
    assign s_ready = slave_auto ? a_s_valid : s_ready_man;
    assign s_rdata = slave_auto ? (a_s_addr ^ 32'hA5A5_0000) : s_rdata_man;

    soc_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut_a (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
        .s_valid(a_s_valid), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(a_grant), .busy(a_busy), .timeout_err(a_timeout_err), .err_clr(err_clr)
    );

    soc_bus_arbiter #(.TIMEOUT_CYCLES(0), .ERR_RDATA(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
        .s_valid(b_s_valid), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(b_grant), .busy(b_busy), .timeout_err(b_timeout_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit m, input bit v, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        if (m) begin
            m1_valid = v; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end else begin
            m0_valid = v; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end
    endtask

    task automatic pushExpect(input bit m, input logic [31:0] rdata);
        exp_t e;
        e.master = m;
        e.rdata  = rdata;
        sb_q.push_back(e);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        err_clr = 1'b0; s_ready_man = 1'b0; s_rdata_man = '0; slave_auto = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Every master ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        logic        r0, r1;
        logic [31:0] d0, d1;
        exp_t        e;
        if (resetn) begin
            r0 = mon_sel ? b_m0_ready : a_m0_ready;
            r1 = mon_sel ? b_m1_ready : a_m1_ready;
            d0 = mon_sel ? b_m0_rdata : a_m0_rdata;
            d1 = mon_sel ? b_m1_rdata : a_m1_rdata;
            if (r0 || r1) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_ready", {30'd0, r1, r0}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_ready_onehot", {30'd0, r1, r0}, e.master ? 32'd2 : 32'd1);
                    checkOutput("sb_rdata", e.master ? d1 : d0, e.rdata);
                end
            end
        end
    end

    initial begin
        int bad;
        mon_sel = 1'b0;
        doReset();
        resetn = 1'b0;
        #1;
        checkOutput("rst_grant", a_grant, 0);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_s_valid", a_s_valid, 0);
        checkOutput("rst_s_addr", a_s_addr, 0);
        checkOutput("rst_ready", {a_m1_ready, a_m0_ready}, 0);
        checkOutput("rst_rdata", a_m0_rdata | a_m1_rdata, 0);
        checkOutput("rst_timeout_err", a_timeout_err, 0);
        tick();
        resetn = 1'b1;

        $display("[TB] single CPU read with one wait cycle");
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
        pushExpect(1'b0, 32'h0000_0013);
        tick();
        checkOutput("t1_s_valid", a_s_valid, 1);
        checkOutput("t1_s_addr", a_s_addr, 32'h0000_0010);
        checkOutput("t1_grant", a_grant, 0);
        checkOutput("t1_busy", a_busy, 1);
        checkOutput("t1_no_early_ready", a_m0_ready, 0);
        tick();
        s_ready_man = 1'b1; s_rdata_man = 32'h0000_0013;
        #1;
        checkOutput("t1_m0_ready", a_m0_ready, 1);
        checkOutput("t1_m0_rdata", a_m0_rdata, 32'h0000_0013);
        checkOutput("t1_m1_ready", a_m1_ready, 0);
        tick();
        s_ready_man = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("t1_ready_pulse", a_m0_ready, 0);
        tick();

        $display("[TB] both masters continuously requesting, zero-wait slave");
        doReset();
        slave_auto = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            pushExpect(i[0], (i[0] ? 32'h0000_0200 : 32'h0000_0100) ^ 32'hA5A5_0000);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("t2_s_valid_alt", a_s_valid, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) begin
                checkOutput("t2_grant_seq", a_grant, (i / 2) % 2);
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        tick();
        slave_auto = 1'b0;
        checkOutput("t2_sb_drained", sb_q.size(), 0);

        $display("[TB] DMA write against a stalled slave");
        applyStimulus(1'b1, 1'b1, 32'h4000_0004, 32'h1122_3344, 4'hF);
        pushExpect(1'b1, 32'hDEAD_BEEF);
        tick();
        checkOutput("t3_grant", a_grant, 1);
        checkOutput("t3_s_addr", a_s_addr, 32'h4000_0004);
        checkOutput("t3_s_wdata", a_s_wdata, 32'h1122_3344);
        checkOutput("t3_s_wstrb", a_s_wstrb, 4'hF);
        for (int i = 1; i < 8; i++) tick();
        checkOutput("t3_still_busy", {a_busy, a_s_valid, a_m1_ready}, 3'b110);
        checkOutput("t3_no_err_yet", a_timeout_err, 0);
        tick();
        checkOutput("t3_abort_s_valid", a_s_valid, 0);
        checkOutput("t3_abort_busy", a_busy, 1);
        checkOutput("t3_abort_ready", a_m1_ready, 1);
        checkOutput("t3_abort_rdata", a_m1_rdata, 32'hDEAD_BEEF);
        checkOutput("t3_abort_m0_ready", a_m0_ready, 0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        tick();
        checkOutput("t3_err_set", a_timeout_err, 1);
        checkOutput("t3_idle", a_busy, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("t3_err_cleared", a_timeout_err, 0);

        $display("[TB] timeout coinciding with err_clr, then a stray s_ready");
        err_clr = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'h0);
        pushExpect(1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("t4_abort_ready", a_m0_ready, 1);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("t4_set_wins", a_timeout_err, 1);
        err_clr = 1'b0;
        s_ready_man = 1'b1; s_rdata_man = 32'h5555_5555;
        #1;
        checkOutput("t4_stray_ready", {a_m1_ready, a_m0_ready}, 0);
        checkOutput("t4_stray_rdata", a_m0_rdata | a_m1_rdata, 0);
        tick();
        s_ready_man = 1'b0;
        checkOutput("t4_err_held", a_timeout_err, 1);
        checkOutput("t4_idle", a_busy, 0);

        $display("[TB] reset asserted mid-transaction");
        applyStimulus(1'b0, 1'b1, 32'h0000_0030, 32'h0, 4'h0);
        tick();
        checkOutput("t5_busy_before", {a_busy, a_s_valid, a_grant}, 3'b110);
        resetn = 1'b0;
        #1;
        checkOutput("t5_rst_s_valid", a_s_valid, 0);
        checkOutput("t5_rst_busy", a_busy, 0);
        checkOutput("t5_rst_grant", a_grant, 0);
        checkOutput("t5_rst_err", a_timeout_err, 0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        tick();
        resetn = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h0000_0050, 32'h0, 4'h0);
        pushExpect(1'b1, 32'h0000_0077);
        tick();
        checkOutput("t5_m1_first", a_grant, 1);
        s_ready_man = 1'b1; s_rdata_man = 32'h0000_0077;
        #1;
        checkOutput("t5_m1_ready", a_m1_ready, 1);
        tick();
        s_ready_man = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        tick();

        $display("[TB] watchdog disabled, 1000-cycle slave stall");
        doReset();
        mon_sel = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0000_0060, 32'h0, 4'h0);
        pushExpect(1'b0, 32'h600D_F00D);
        bad = 0;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (!(b_s_valid && b_busy && !b_m0_ready && !b_timeout_err)) bad++;
        end
        checkOutput("t6_stall_cycles_bad", bad, 0);
        tick();
        s_ready_man = 1'b1; s_rdata_man = 32'h600D_F00D;
        #1;
        checkOutput("t6_ready_1001", b_m0_ready, 1);
        checkOutput("t6_rdata", b_m0_rdata, 32'h600D_F00D);
        tick();
        s_ready_man = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("t6_no_err", b_timeout_err, 0);
        checkOutput("t6_idle", b_busy, 0);
        tick();
        tick();
        checkOutput("sb_final_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
